// File: rtl/l3_host.sv
// Host command front-end: captures a command, strobes the core, moves write/read words, returns a response.
// Optional watchdog on stalled data/response phases: define L3_HOST_TMO_EN.
module l3_host #(
  parameter int TMO_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_wr,
  input  logic [7:0]  req_op,
  input  logic [15:0] req_extend,
  input  logic [15:0] req_size,
  input  logic [3:0]  req_id,
  input  logic [31:0] hwd,
  input  logic        hwd_vld,
  output logic        hwd_rdy,
  output logic [31:0] hrd,
  output logic        hrd_vld,
  input  logic        hrd_rdy,
  output logic        done_vld,
  output logic [7:0]  done_resp,
  output logic        l3_en,
  output logic [7:0]  l3_op,
  output logic [15:0] l3_extend,
  output logic [15:0] l3_size,
  output logic [3:0]  l3_id,
  output logic [31:0] l3_wd,
  output logic        l3_wd_vld,
  input  logic        core_wd_rdy,
  input  logic [31:0] core_rd,
  input  logic        core_rd_vld,
  output logic        l3_rd_rdy,
  input  logic [7:0]  core_resp,
  input  logic        core_resp_vld,
  output logic        resp_rdy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_RESP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_op;
  logic [15:0] r_extend;
  logic [15:0] r_size;
  logic [3:0]  r_id;
  logic        r_wr;
  logic [15:0] r_cnt;
  logic [7:0]  r_resp;

  logic        w_capture;
  logic        w_xfer;
  logic        w_resp_take;
  logic        w_last;
  logic        w_tmo_hit;

  assign w_capture   = (r_state == S_IDLE) & req_vld;
  assign w_xfer      = ((r_state == S_WDATA) & hwd_vld & core_wd_rdy) |
                       ((r_state == S_RDATA) & core_rd_vld & hrd_rdy);
  // An early response during a data phase is taken just like one in RESP.
  assign w_resp_take = core_resp_vld &
                       ((r_state == S_WDATA) | (r_state == S_RDATA) | (r_state == S_RESP));
  assign w_last      = w_xfer & (r_cnt == 16'd1);

`ifdef L3_HOST_TMO_EN
  logic [31:0] r_tmo;
  logic        w_wait;

  assign w_wait    = (r_state == S_WDATA) | (r_state == S_RDATA) | (r_state == S_RESP);
  assign w_tmo_hit = w_wait & ~w_xfer & ~w_resp_take & (r_tmo == 32'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (!w_wait || w_xfer || w_resp_take || w_tmo_hit) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 32'd1;
    end
  end
`else
  // Watchdog absent: the limit is only referenced so the parameter stays part of the interface.
  assign w_tmo_hit = (TMO_CYC < 0);
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_vld) w_next = S_CMD;
      S_CMD: begin
        if (r_size == 16'd0) w_next = S_RESP;
        else if (r_wr)       w_next = S_WDATA;
        else                 w_next = S_RDATA;
      end
      S_WDATA, S_RDATA: begin
        if (w_resp_take)     w_next = S_DONE;
        else if (w_last)     w_next = S_RESP;
        else if (w_tmo_hit)  w_next = S_DONE;
      end
      S_RESP: begin
        if (w_resp_take || w_tmo_hit) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_extend <= '0;
      r_size   <= '0;
      r_id     <= '0;
      r_wr     <= 1'b0;
      r_cnt    <= '0;
      r_resp   <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_op     <= req_op;
        r_extend <= req_extend;
        r_size   <= req_size;
        r_id     <= req_id;
        r_wr     <= req_wr;
        r_cnt    <= req_size;
      end else if (w_xfer) begin
        r_cnt <= r_cnt - 16'd1;
      end
      if (w_resp_take) begin
        r_resp <= core_resp;
      end else if (w_tmo_hit) begin
        r_resp <= 8'hFF;
      end
    end
  end

  // req_rdy is the only output high in the reset state, so it is masked while reset is held.
  assign req_rdy   = (r_state == S_IDLE) & rst_n;
  assign l3_en     = (r_state == S_CMD);
  assign l3_op     = r_op;
  assign l3_extend = r_extend;
  assign l3_size   = r_size;
  assign l3_id     = r_id;
  assign l3_wd     = (r_state == S_WDATA) ? hwd : '0;
  assign l3_wd_vld = (r_state == S_WDATA) & hwd_vld;
  assign hwd_rdy   = (r_state == S_WDATA) & core_wd_rdy;
  assign hrd       = (r_state == S_RDATA) ? core_rd : '0;
  assign hrd_vld   = (r_state == S_RDATA) & core_rd_vld;
  assign l3_rd_rdy = (r_state == S_RDATA) & hrd_rdy;
  assign resp_rdy  = (r_state == S_RESP);
  assign done_vld  = (r_state == S_DONE);
  assign done_resp = r_resp;

endmodule

// File: tb/tb_l3_host.sv
// Directed bench for l3_host: write/read bursts, stalls, zero-length, early error, mid-burst reset, optional watchdog.
module tb_l3_host;

  logic        clk;
  logic        rst_n;
  logic        req_vld, req_rdy, req_wr;
  logic [7:0]  req_op;
  logic [15:0] req_extend, req_size;
  logic [3:0]  req_id;
  logic [31:0] hwd;
  logic        hwd_vld, hwd_rdy;
  logic [31:0] hrd;
  logic        hrd_vld, hrd_rdy;
  logic        done_vld;
  logic [7:0]  done_resp;
  logic        l3_en;
  logic [7:0]  l3_op;
  logic [15:0] l3_extend, l3_size;
  logic [3:0]  l3_id;
  logic [31:0] l3_wd;
  logic        l3_wd_vld, core_wd_rdy;
  logic [31:0] core_rd;
  logic        core_rd_vld, l3_rd_rdy;
  logic [7:0]  core_resp;
  logic        core_resp_vld, resp_rdy;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_en = 0, cnt_done = 0, cnt_wv = 0, cnt_hv = 0, cnt_wx = 0, cnt_rx = 0;

  l3_host #(.TMO_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_op(req_op),
    .req_extend(req_extend), .req_size(req_size), .req_id(req_id),
    .hwd(hwd), .hwd_vld(hwd_vld), .hwd_rdy(hwd_rdy),
    .hrd(hrd), .hrd_vld(hrd_vld), .hrd_rdy(hrd_rdy),
    .done_vld(done_vld), .done_resp(done_resp),
    .l3_en(l3_en), .l3_op(l3_op), .l3_extend(l3_extend), .l3_size(l3_size), .l3_id(l3_id),
    .l3_wd(l3_wd), .l3_wd_vld(l3_wd_vld), .core_wd_rdy(core_wd_rdy),
    .core_rd(core_rd), .core_rd_vld(core_rd_vld), .l3_rd_rdy(l3_rd_rdy),
    .core_resp(core_resp), .core_resp_vld(core_resp_vld), .resp_rdy(resp_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    cnt_en   += int'(l3_en);
    cnt_done += int'(done_vld);
    cnt_wv   += int'(l3_wd_vld);
    cnt_hv   += int'(hrd_vld);
    cnt_wx   += int'(l3_wd_vld & hwd_rdy);
    cnt_rx   += int'(hrd_vld & l3_rd_rdy);
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no end of test, expected completion");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int n;
    logic rdy;
    logic [31:0] rw [3];
    rw = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

    rst_n = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_op = '0; req_extend = '0;
    req_size = '0; req_id = '0; hwd = '0; hwd_vld = 1'b0; hrd_rdy = 1'b0;
    core_wd_rdy = 1'b0; core_rd = '0; core_rd_vld = 1'b0; core_resp = '0; core_resp_vld = 1'b0;

    // Reset state
    #2;
    chkb("rst_req_rdy", req_rdy, 1'b0);
    chkb("rst_done_vld", done_vld, 1'b0);
    chkb("rst_l3_en", l3_en, 1'b0);
    chk("rst_done_resp", 32'(done_resp), 32'h0);
    chk("rst_l3_op", 32'(l3_op), 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    chkb("idle_req_rdy", req_rdy, 1'b1);
    chkb("idle_resp_rdy", resp_rdy, 1'b0);

    // Write, size 4, core_wd_rdy toggling
    req_vld = 1'b1; req_wr = 1'b1; req_op = 8'h21; req_extend = 16'hBEEF; req_size = 16'd4; req_id = 4'h5;
    cyc();
    req_vld = 1'b0; req_op = 8'hEE; req_size = 16'd0; req_extend = 16'h0; req_id = 4'h0;
    #1;
    chkb("wr_cmd_l3_en", l3_en, 1'b1);
    chk("wr_cmd_op", 32'(l3_op), 32'h21);
    chk("wr_cmd_size", 32'(l3_size), 32'd4);
    chk("wr_cmd_ext", 32'(l3_extend), 32'hBEEF);
    chk("wr_cmd_id", 32'(l3_id), 32'h5);
    chkb("wr_cmd_req_rdy", req_rdy, 1'b0);
    cyc();
    idx = 0;
    for (int i = 0; i < 20 && idx < 4; i++) begin
      rdy = (i % 2 == 1);
      hwd = 32'hA5A5_0000 + 32'(idx); hwd_vld = 1'b1; core_wd_rdy = rdy;
      #1;
      chkb("wr_wd_vld", l3_wd_vld, 1'b1);
      chk("wr_wd_data", l3_wd, 32'hA5A5_0000 + 32'(idx));
      chkb("wr_hwd_rdy", hwd_rdy, rdy);
      chkb("wr_no_en", l3_en, 1'b0);
      if (rdy) idx++;
      cyc();
    end
    // Still offering data: must be in RESP after exactly four words
    #1;
    chkb("wr_resp_rdy", resp_rdy, 1'b1);
    chkb("wr_resp_wd_vld", l3_wd_vld, 1'b0);
    chkb("wr_resp_hwd_rdy", hwd_rdy, 1'b0);
    cyc();
    #1;
    chkb("wr_resp_wait", resp_rdy, 1'b1);
    chkb("wr_resp_wait_done", done_vld, 1'b0);
    core_resp = 8'h00; core_resp_vld = 1'b1;
    cyc();
    core_resp_vld = 1'b0; hwd_vld = 1'b0; core_wd_rdy = 1'b0;
    req_vld = 1'b1; req_wr = 1'b0; req_op = 8'h99; req_size = 16'd2;
    #1;
    chkb("wr_done_vld", done_vld, 1'b1);
    chk("wr_done_resp", 32'(done_resp), 32'h00);
    chkb("wr_done_req_rdy", req_rdy, 1'b0);
    cyc();
    req_vld = 1'b0;
    #1;
    chkb("wr_idle_req_rdy", req_rdy, 1'b1);
    chkb("wr_idle_done", done_vld, 1'b0);
    chk("wr_en_pulses", 32'(cnt_en), 32'd1);
    chk("wr_words", 32'(cnt_wx), 32'd4);
    chk("wr_done_pulses", 32'(cnt_done), 32'd1);
    chk("wr_op_stable", 32'(l3_op), 32'h21);
    cyc();
    #1;
    chkb("done_req_ignored", l3_en, 1'b0);

    // Read, size 3, hrd_rdy low 5 cycles after first word
    req_vld = 1'b1; req_wr = 1'b0; req_op = 8'h30; req_extend = 16'h0001; req_size = 16'd3; req_id = 4'h2;
    cyc();
    req_vld = 1'b0;
    #1;
    chkb("rd_cmd_l3_en", l3_en, 1'b1);
    chk("rd_cmd_op", 32'(l3_op), 32'h30);
    cyc();
    idx = 0;
    for (int i = 0; i < 20 && idx < 3; i++) begin
      rdy = (i == 0) || (i >= 6);
      core_rd_vld = 1'b1; core_rd = rw[idx]; hrd_rdy = rdy;
      #1;
      chk("rd_hrd", hrd, rw[idx]);
      chkb("rd_hrd_vld", hrd_vld, 1'b1);
      chkb("rd_l3_rd_rdy", l3_rd_rdy, rdy);
      if (rdy) idx++;
      cyc();
    end
    core_resp = 8'h5A; core_resp_vld = 1'b1;
    #1;
    chkb("rd_resp_hrd_vld", hrd_vld, 1'b0);
    chkb("rd_resp_rd_rdy", l3_rd_rdy, 1'b0);
    chkb("rd_resp_rdy", resp_rdy, 1'b1);
    cyc();
    core_resp_vld = 1'b0; core_rd_vld = 1'b0; hrd_rdy = 1'b0;
    #1;
    chkb("rd_done_vld", done_vld, 1'b1);
    chk("rd_done_resp", 32'(done_resp), 32'h5A);
    cyc();
    #1;
    chk("rd_words", 32'(cnt_rx), 32'd3);
    chk("rd_done_pulses", 32'(cnt_done), 32'd2);
    chk("rd_en_pulses", 32'(cnt_en), 32'd2);

    // Size 0: CMD then RESP, data valids stay low even with inputs active
    req_vld = 1'b1; req_wr = 1'b1; req_op = 8'h40; req_size = 16'd0;
    hwd_vld = 1'b1; core_wd_rdy = 1'b1; core_rd_vld = 1'b1; hrd_rdy = 1'b1;
    cyc();
    req_vld = 1'b0;
    #1;
    chkb("z_cmd_l3_en", l3_en, 1'b1);
    chkb("z_cmd_wd_vld", l3_wd_vld, 1'b0);
    cyc();
    core_resp = 8'h11; core_resp_vld = 1'b1;
    #1;
    chkb("z_resp_rdy", resp_rdy, 1'b1);
    chkb("z_resp_wd_vld", l3_wd_vld, 1'b0);
    chkb("z_resp_hrd_vld", hrd_vld, 1'b0);
    cyc();
    core_resp_vld = 1'b0;
    #1;
    chkb("z_done_vld", done_vld, 1'b1);
    chk("z_done_resp", 32'(done_resp), 32'h11);
    cyc();
    hwd_vld = 1'b0; core_wd_rdy = 1'b0; core_rd_vld = 1'b0; hrd_rdy = 1'b0;
    #1;
    chk("z_wd_vld_total", 32'(cnt_wv), 32'd8);
    chk("z_hrd_vld_total", 32'(cnt_hv), 32'd8);

    // Write size 8, error response after word 2
    req_vld = 1'b1; req_wr = 1'b1; req_op = 8'h22; req_size = 16'd8;
    cyc();
    req_vld = 1'b0;
    cyc();
    hwd = 32'hE000_0000; hwd_vld = 1'b1; core_wd_rdy = 1'b1;
    #1;
    chkb("err_hwd_rdy", hwd_rdy, 1'b1);
    cyc();
    hwd = 32'hE000_0001;
    cyc();
    hwd_vld = 1'b0; core_resp = 8'h03; core_resp_vld = 1'b1;
    #1;
    chkb("err_wd_vld", l3_wd_vld, 1'b0);
    chkb("err_req_rdy", req_rdy, 1'b0);
    cyc();
    core_resp_vld = 1'b0; core_wd_rdy = 1'b0;
    #1;
    chkb("err_done_vld", done_vld, 1'b1);
    chk("err_done_resp", 32'(done_resp), 32'h03);
    chkb("err_done_req_rdy", req_rdy, 1'b0);
    cyc();
    #1;
    chkb("err_req_rdy_2cyc", req_rdy, 1'b1);
    chkb("err_done_once", done_vld, 1'b0);
    chk("err_words", 32'(cnt_wx), 32'd6);

    // Reset during read word 2
    req_vld = 1'b1; req_wr = 1'b0; req_op = 8'h33; req_size = 16'd4; req_id = 4'h9;
    cyc();
    req_vld = 1'b0;
    cyc();
    core_rd_vld = 1'b1; hrd_rdy = 1'b1; core_rd = 32'hCAFE_0001;
    cyc();
    core_rd = 32'hCAFE_0002;
    #1;
    chk("rst_mid_hrd_before", hrd, 32'hCAFE_0002);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hrd", hrd, 32'h0);
    chkb("rst_mid_hrd_vld", hrd_vld, 1'b0);
    chkb("rst_mid_rd_rdy", l3_rd_rdy, 1'b0);
    chkb("rst_mid_req_rdy", req_rdy, 1'b0);
    chk("rst_mid_op", 32'(l3_op), 32'h0);
    chk("rst_mid_size", 32'(l3_size), 32'h0);
    chk("rst_mid_id", 32'(l3_id), 32'h0);
    chk("rst_mid_done_resp", 32'(done_resp), 32'h0);
    chkb("rst_mid_done_vld", done_vld, 1'b0);
    cyc(); cyc();
    rst_n = 1'b1; core_rd_vld = 1'b0; hrd_rdy = 1'b0;
    req_vld = 1'b1; req_wr = 1'b1; req_op = 8'h55; req_size = 16'd1; req_id = 4'h3;
    #1;
    chk("rst_no_done", 32'(cnt_done), 32'd4);
    cyc();
    req_vld = 1'b0;
    #1;
    chkb("post_cmd_en", l3_en, 1'b1);
    chk("post_cmd_op", 32'(l3_op), 32'h55);
    cyc();
    hwd = 32'hDEAD_BEEF; hwd_vld = 1'b1; core_wd_rdy = 1'b1;
    #1;
    chk("post_wd", l3_wd, 32'hDEAD_BEEF);
    cyc();
    hwd_vld = 1'b0; core_wd_rdy = 1'b0; core_resp = 8'h7E; core_resp_vld = 1'b1;
    #1;
    chkb("post_resp_rdy", resp_rdy, 1'b1);
    cyc();
    core_resp_vld = 1'b0;
    #1;
    chkb("post_done_vld", done_vld, 1'b1);
    chk("post_done_resp", 32'(done_resp), 32'h7E);
    cyc();
    #1;
    chkb("post_req_rdy", req_rdy, 1'b1);
    chk("post_done_pulses", 32'(cnt_done), 32'd5);

`ifdef L3_HOST_TMO_EN
    // Watchdog: no response ever arrives
    req_vld = 1'b1; req_wr = 1'b0; req_op = 8'h66; req_size = 16'd0;
    cyc();
    req_vld = 1'b0;
    cyc();
    n = 0;
    while (done_vld !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk("tmo_latency", 32'(n), 32'd16);
    chk("tmo_done_resp", 32'(done_resp), 32'hFF);
    cyc();
    #1;
    chkb("tmo_req_rdy", req_rdy, 1'b1);
`else
    n = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/l3_host.md
L3_HOST -- requirements
Module: l3_host
Interface
REQ-001 TMO_CYC, 4096, idle-cycle limit for the watchdog (used only with L3_HOST_TMO_EN).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_vld  in  1  host command request valid.
REQ-005 req_rdy  out  1  block is IDLE and can accept a command.
REQ-006 req_wr  in  1  1 = write data phase (host to core), 0 = read data phase (core to host).
REQ-007 req_op  in  8  command opcode.
REQ-008 req_extend  in  16  command extension field.
REQ-009 req_size  in  16  data-phase length in 32-bit words; 0 = no data phase.
REQ-010 req_id  in  4  session identifier.
REQ-011 hwd  in  32  host write word.
REQ-012 hwd_vld  in  1  host write word valid.
REQ-013 hwd_rdy  out  1  host write word accepted this cycle.
REQ-014 hrd  out  32  read word to host.
REQ-015 hrd_vld  out  1  hrd valid.
REQ-016 hrd_rdy  in  1  host accepts hrd.
REQ-017 done_vld  out  1  one-cycle pulse, command complete.
REQ-018 done_resp  out  8  captured response code, valid with done_vld.
REQ-019 l3_en  out  1  one-cycle command strobe to core.
REQ-020 l3_op  out  8  registered opcode.
REQ-021 l3_extend  out  16  registered extension.
REQ-022 l3_size  out  16  registered size.
REQ-023 l3_id  out  4  registered session id.
REQ-024 l3_wd  out  32  write word to core (= hwd).
REQ-025 l3_wd_vld  out  1  write word valid to core.
REQ-026 core_wd_rdy  in  1  core accepts write word.
REQ-027 core_rd  in  32  read word from core.
REQ-028 core_rd_vld  in  1  core_rd valid.
REQ-029 l3_rd_rdy  out  1  block accepts core_rd (= hrd_rdy in RDATA).
REQ-030 core_resp  in  8  response code from core.
REQ-031 core_resp_vld  in  1  response valid.
REQ-032 resp_rdy  out  1  block accepts response.
Function
REQ-033 FSM states IDLE, CMD, WDATA, RDATA, RESP, DONE; req_rdy=1 only in IDLE.
REQ-034 IDLE with req_vld: capture req_op/extend/size/id/wr into l3_* registers, load 16-bit word counter with req_size, go CMD; l3_* fields remain stable until next capture.
REQ-035 CMD lasts exactly one cycle with l3_en=1; next state WDATA if req_wr and size!=0, RDATA if !req_wr and size!=0, else RESP.
REQ-036 WDATA: l3_wd_vld=hwd_vld, hwd_rdy=core_wd_rdy, combinational pass-through; transfer when hwd_vld&core_wd_rdy; counter decrements per transfer; final transfer (counter=1) moves to RESP.
REQ-037 RDATA: hrd=core_rd, hrd_vld=core_rd_vld, l3_rd_rdy=hrd_rdy; transfer when core_rd_vld&hrd_rdy; decrement and exit to RESP as in REQ-036.
REQ-038 RESP: resp_rdy=1; on core_resp_vld capture core_resp into done_resp, go DONE; core_resp_vld in WDATA/RDATA (early error) likewise ends the data phase immediately, remaining words discarded.
REQ-039 DONE lasts one cycle with done_vld=1, then IDLE; req_vld in DONE is ignored until IDLE.
REQ-040 Outside their states, l3_en, l3_wd_vld, hwd_rdy, hrd_vld, l3_rd_rdy, resp_rdy, done_vld are 0.
Reset
REQ-041 rst_n low at any time (including mid data phase): immediately IDLE, all outputs and registers 0, counter 0, no done_vld issued.
Configuration
REQ-042 L3_HOST_TMO_EN defined: counter of consecutive cycles in WDATA/RDATA/RESP without a transfer or response; reaching TMO_CYC forces DONE with done_resp=8'hFF; undefined: no watchdog, wait indefinitely.
Verification
REQ-043 Write op=8'h21, size=4, core_wd_rdy toggling -> one l3_en pulse, exactly 4 words in order, done_resp=core_resp=8'h00.
REQ-044 Read size=3, hrd_rdy low 5 cycles mid-burst -> l3_rd_rdy low likewise, 3 words delivered unchanged, single done_vld.
REQ-045 size=0 -> CMD then RESP directly; no l3_wd_vld/hrd_vld ever asserted.
REQ-046 Write size=8, core_resp_vld=1 with 8'h03 after word 2 -> DONE, done_resp=8'h03, req_rdy=1 two cycles later.
REQ-047 rst_n low during RDATA word 2 -> all outputs 0 asynchronously; new command after release completes normally.
REQ-048 L3_HOST_TMO_EN, TMO_CYC=16, core never responds -> done_vld 16 cycles after entering RESP, done_resp=8'hFF.
